alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- 8-bit (parameterisable) integer ALU for the ProtoCore datapath.
- Takes two operands and a 3-bit opcode, and computes add, subtract, bitwise logic, complement or 1-bit shift.
- Produces a result plus carry and zero flags.
- Output stage is registered: result and flags are valid one clock after the operands are accepted.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid this cycle; captured at rising clk
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for NOT, SHL, SHR)
- opcode  input  3  operation select
- out  output  WIDTH  registered result
- carry  output  1  registered carry/borrow/shift-out flag
- zero  output  1  registered zero flag
- out_valid  output  1  high for one cycle when out/carry/zero hold a new result

Behaviour:
- Opcode map:
  - 000 ADD: out = a + b mod 2^WIDTH; carry = carry out of MSB.
  - 001 SUB: out = a - b mod 2^WIDTH; carry = borrow (1 when a < b unsigned).
  - 010 AND: out = a & b; carry = 0.
  - 011 OR: out = a | b; carry = 0.
  - 100 XOR: out = a ^ b; carry = 0.
  - 101 NOT: out = ~a; carry = 0.
  - 110 SHL: out = a << 1, LSB filled with 0; carry = a[MSB].
  - 111 SHR: out = a >> 1 (logical), MSB filled with 0; carry = a[0].
- zero = 1 iff the new out == 0, for every opcode.
- All arithmetic is unsigned. No overflow flag. Result truncated to WIDTH.
- Latency:
  - in_valid=1 at rising edge N → out/carry/zero/out_valid updated at edge N; visible in cycle N+1.
  - Throughput one operation per cycle.
  - Back-to-back valid inputs produce back-to-back results.
- in_valid=0 at an edge:
  - out, carry and zero hold their previous values.
  - out_valid is driven 0.
- out_valid is a pure registered copy of in_valid. No backpressure; results must be consumed when out_valid=1.
- Reset (rst_n low, asynchronous, any time including mid-stream):
  - out=0, carry=0, zero=0, out_valid=0 immediately.
  - Any in-flight operation is discarded.
  - The first capture happens on the first rising clk after rst_n deasserts, if in_valid=1.
- Result logic is purely combinational from a/b/opcode into the output register. No internal state besides the output registers.
- Opcode decode is full; no illegal opcodes exist.
- Inputs need only be stable around the capturing edge.

Test Plan:
- ADD:
  - a=0x80, b=0x80, in_valid=1 → next cycle out=0x00, carry=1, zero=1, out_valid=1.
  - a=0x01, b=0x02 → out=0x03, carry=0, zero=0.
- SUB:
  - a=0x01, b=0x02 → out=0xFF, carry=1, zero=0.
  - a=0x40, b=0x40 → out=0x00, carry=0, zero=1.
- Logic, sweep a over 0x00,0x11,…,0xFF and b over 0x00,0x33,…,0xFF:
  - AND/OR/XOR out equals a&b, a|b, a^b; carry=0; zero correct.
  - AND a=0xF0, b=0x0F → out=0x00, zero=1.
- NOT/shifts:
  - NOT a=0xFF → out=0x00, zero=1.
  - SHL a=0x88 → out=0x10, carry=1.
  - SHR a=0x11 → out=0x08, carry=1.
  - SHR a=0x01 → out=0x00, carry=1, zero=1.
- Handshake:
  - Three consecutive valid ops → three consecutive out_valid pulses with matching results.
  - Then in_valid=0 → out_valid=0, out/flags hold the last result.
- Reset mid-stream: assert rst_n=0 between clock edges while valid ops stream → out=0x00, carry=0, zero=0, out_valid=0 immediately. After release, the first valid op produces a correct result one cycle later.

Source files
------------

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Unsigned integer ALU with a registered output stage. A result and its
//   carry/zero flags appear one clock after the operands are captured.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   a/b/opcode are valid and are captured at this rising edge
//   a, b       operands (b is unused by NOT, SHL and SHR)
//   opcode     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT,
//              110 SHL, 111 SHR
//   out        registered result
//   carry      registered carry (ADD), borrow (SUB) or shifted-out bit
//   zero       registered flag, set when out is zero
//   out_valid  one-cycle pulse marking a new out/carry/zero
//
// Handshake: in_valid/out_valid form a valid-only stream. There is no ready
// signal in either direction; every in_valid cycle is accepted and its result
// is presented with out_valid exactly one cycle later, so the consumer must
// take the result in that cycle. Between results out/carry/zero hold.
// ---------------------------------------------------------------------------
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             zero_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;

    // One extra bit on each side so the MSB of the widened result is the
    // carry out (add) or the borrow (subtract, wraps when a < b).
    assign sum_c  = {1'b0, a} + {1'b0, b};
    assign diff_c = {1'b0, a} - {1'b0, b};

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        case (op_e'(opcode))
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
            end
            OP_SUB: begin
                res_c   = diff_c[WIDTH-1:0];
                carry_c = diff_c[WIDTH];
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            OP_NOT: res_c = ~a;
            OP_SHL: begin
                res_c   = {a[WIDTH-2:0], 1'b0};
                carry_c = a[WIDTH-1];
            end
            OP_SHR: begin
                res_c   = {1'b0, a[WIDTH-1:1]};
                carry_c = a[0];
            end
            default: begin
                res_c   = '0;
                carry_c = 1'b0;
            end
        endcase
    end

    assign zero_c = (res_c == '0);

    // Result registers load only on accepted operations; out_valid simply
    // follows in_valid so it is a one-cycle pulse per operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out   <= res_c;
                carry <= carry_c;
                zero  <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   opcode = '0;
    logic [W-1:0] out;
    logic         carry;
    logic         zero;
    logic         out_valid;

    always #5 clk = ~clk;

    alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid)
    );

    // ---------------- scoreboard ----------------
    // Expected word layout: {out, carry, zero}
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_w = '0;
    int           n_pass = 0;
    int           n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model from the operation definitions using integer arithmetic.
    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] av,
                                           input logic [W-1:0] bv);
        int ai = int'(av);
        int bi = int'(bv);
        int m  = 1 << W;
        int r  = 0;
        int c  = 0;
        case (op)
            3'd0: begin r = (ai + bi) % m; c = ((ai + bi) >= m) ? 1 : 0; end
            3'd1: begin r = (ai - bi + m) % m; c = (ai < bi) ? 1 : 0; end
            3'd2: r = int'(av & bv);
            3'd3: r = int'(av | bv);
            3'd4: r = int'(av ^ bv);
            3'd5: r = (m - 1) - ai;
            3'd6: begin r = (ai * 2) % m; c = (ai >= m / 2) ? 1 : 0; end
            default: begin r = ai / 2; c = ai % 2; end
        endcase
        return {r[W-1:0], c[0], (r == 0)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W+1:0] exp_w);
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        exp_q.push_back(exp_w);
    endtask

    task automatic capture(input string name);
        logic [W+1:0] e;
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            last_w = e;
            chk(name, 32'({out, carry, zero}), 32'(e));
        end
    endtask

    task automatic drive_op(input string name, input logic [2:0] op, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic [W+1:0] exp_w);
        @(negedge clk);
        apply(op, av, bv, exp_w);
        capture(name);
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 3'($urandom);
        @(posedge clk);
        #1;
        chk({name, "_valid_low"}, 32'(out_valid), 32'd0);
        chk({name, "_hold"}, 32'({out, carry, zero}), 32'(last_w));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] e_out;
        logic         e_carry;
        logic         e_zero;
        string        name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] sa;
        logic [W-1:0] sb;

        vecs[0]  = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, "add_80_80"};
        vecs[1]  = '{3'b000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "add_01_02"};
        vecs[2]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, "add_ff_01"};
        vecs[3]  = '{3'b001, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, "sub_01_02"};
        vecs[4]  = '{3'b001, 8'h40, 8'h40, 8'h00, 1'b0, 1'b1, "sub_40_40"};
        vecs[5]  = '{3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, "and_f0_0f"};
        vecs[6]  = '{3'b011, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, "or_0f_f0"};
        vecs[7]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, "xor_aa_aa"};
        vecs[8]  = '{3'b101, 8'hFF, 8'hA5, 8'h00, 1'b0, 1'b1, "not_ff"};
        vecs[9]  = '{3'b101, 8'h00, 8'hA5, 8'hFF, 1'b0, 1'b0, "not_00"};
        vecs[10] = '{3'b110, 8'h88, 8'hA5, 8'h10, 1'b1, 1'b0, "shl_88"};
        vecs[11] = '{3'b110, 8'h7F, 8'hA5, 8'hFE, 1'b0, 1'b0, "shl_7f"};
        vecs[12] = '{3'b111, 8'h11, 8'hA5, 8'h08, 1'b1, 1'b0, "shr_11"};
        vecs[13] = '{3'b111, 8'h01, 8'hA5, 8'h00, 1'b1, 1'b1, "shr_01"};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_state", 32'({out, carry, zero, out_valid}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table, streamed back-to-back
        foreach (vecs[i])
            drive_op(vecs[i].name, vecs[i].op, vecs[i].av, vecs[i].bv,
                     {vecs[i].e_out, vecs[i].e_carry, vecs[i].e_zero});
        idle_cycle("after_table");

        // Logic sweep: a and b in steps of 0x11 / 0x33
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 6; bi++) begin
                sa = W'(ai * 17);
                sb = W'(bi * 51);
                for (int op = 2; op <= 4; op++)
                    drive_op("logic_sweep", 3'(op), sa, sb, model(3'(op), sa, sb));
            end
        end

        // Handshake: three back-to-back ops, then idle holds the last result
        drive_op("hs_0", 3'b000, 8'h12, 8'h34, model(3'b000, 8'h12, 8'h34));
        drive_op("hs_1", 3'b001, 8'h10, 8'h20, model(3'b001, 8'h10, 8'h20));
        drive_op("hs_2", 3'b110, 8'hC3, 8'h00, model(3'b110, 8'hC3, 8'h00));
        idle_cycle("hs_idle0");
        idle_cycle("hs_idle1");

        // Reset mid-stream: a valid op is pending when reset hits between edges
        drive_op("pre_rst", 3'b001, 8'h01, 8'h02, model(3'b001, 8'h01, 8'h02));
        @(negedge clk);
        apply(3'b000, 8'hFF, 8'hFF, model(3'b000, 8'hFF, 8'hFF));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({out, carry, zero, out_valid}), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held", 32'({out, carry, zero, out_valid}), 32'd0);
        exp_q.delete();
        last_w = '0;
        @(negedge clk);
        rst_n = 1'b1;
        apply(3'b000, 8'h80, 8'h7F, model(3'b000, 8'h80, 8'h7F));
        capture("post_rst_first");
        idle_cycle("post_rst_idle");

        // Randomized stream with random idle gaps
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle("rand_idle");
            end else begin
                rop = 3'($urandom_range(0, 7));
                ra  = W'($urandom);
                rb  = W'($urandom);
                drive_op("rand_op", rop, ra, rb, model(rop, ra, rb));
            end
        end

        // ---------------- final report ----------------
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
